am_img_avg: RTL and testbench

Next-generation image-driven alignment motor stepper. Per-frame fibre cladding/core edge positions feed an accumulator that averages 2^C_AVG_LOG2 consecutive motion-free frames before deciding. The averaged, eccentricity-compensated gap error is converted into a signed step count through an external step LUT. The block sits between the image edge detector and the motor step controller. Scan direction (L2R) is a runtime input rather than a build parameter.

---
 rtl/am_img_avg.sv | 174 +++++++++++++++++
 tb/tb_am_img_avg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_img_avg.sv
// am_img_avg: averages 2^C_AVG_LOG2 motion-free edge frames and turns the gap error into a signed step via an external LUT.
// Build option: define AM_IMG_ADDR_CLAMP_EN to saturate the LUT address (and clear o_ok) when |err| exceeds the LUT range.
module am_img_avg #(
  parameter int C_IMG_HW            = 12,
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_AVG_LOG2          = 2,
  parameter int C_LUT_AW            = 10,
  parameter int C_LUT_LATENCY       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           l2r,
  input  logic                           done_if_img_invalid,
  input  logic                           req_ecf,
  input  logic                           req_dep_img,
  input  logic [C_IMG_HW-1:0]            req_img_dst,
  input  logic [C_IMG_HW-1:0]            req_img_tol,
  input  logic                           img_pulse,
  input  logic                           img_l_valid,
  input  logic                           img_r_valid,
  input  logic                           img_lo_valid,
  input  logic                           img_ro_valid,
  input  logic [C_IMG_HW-1:0]            img_lo_y,
  input  logic [C_IMG_HW-1:0]            img_ro_y,
  input  logic                           img_li_valid,
  input  logic                           img_ri_valid,
  input  logic [C_IMG_HW-1:0]            img_li_y,
  input  logic [C_IMG_HW-1:0]            img_ri_y,
  input  logic                           m_state,
  input  logic                           m_dep_state,
  output logic [C_LUT_AW-1:0]            rd_addr,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] rd_data,
  output logic                           o_pulse,
  output logic [C_STEP_NUMBER_WIDTH-1:0] o_step,
  output logic                           o_ok,
  output logic                           o_should_start,
  output logic [C_IMG_HW:0]              o_err
);
  localparam int W1 = C_IMG_HW + 1;
  localparam int WA = W1 + C_AVG_LOG2;
  localparam int CW = C_AVG_LOG2 + 1;
  localparam int NF = 1 << C_AVG_LOG2;

  typedef enum logic [1:0] {ACC, CALC, LUT, EMIT} state_t;
  state_t state;

  logic                           self_mv, dep_mv;
  logic [1:0]                     self_hist, dep_hist;
  logic signed [WA-1:0]           acc;
  logic [CW-1:0]                  count;
  logic                           all_dep_still;
  logic [1:0]                     calc_step;
  logic [2:0]                     wait_cnt;
  logic signed [W1-1:0]           avg, err;
  logic                           needback, ok;
  logic [C_STEP_NUMBER_WIDTH-1:0] lut_data;

  // Motion seen since the previous frame, including the strobe cycle itself.
  logic       self_now, dep_now, self_still, dep_still;
  logic [1:0] self_hist_new, dep_hist_new;
  assign self_now      = self_mv | m_state;
  assign dep_now       = dep_mv | m_dep_state;
  assign self_hist_new = {self_hist[0], self_now};
  assign dep_hist_new  = {dep_hist[0], dep_now};
  assign self_still    = (self_hist_new == 2'b00);
  assign dep_still     = (dep_hist_new == 2'b00);

  logic signed [W1-1:0] od_raw, id_raw, od, id, ecc, pos;
  logic signed [WA-1:0] pos_ext;
  assign od_raw  = $signed({1'b0, img_lo_y}) - $signed({1'b0, img_ro_y});
  assign id_raw  = $signed({1'b0, img_li_y}) - $signed({1'b0, img_ri_y});
  assign od      = l2r ? od_raw : -od_raw;
  assign id      = l2r ? id_raw : -id_raw;
  assign ecc     = od - id;
  assign pos     = (req_ecf & img_li_valid & img_ri_valid) ? id - (ecc >>> 2) : od;
  assign pos_ext = WA'(pos);

  logic accept;
  assign accept = enable & req_dep_img & img_l_valid & img_r_valid &
                  img_lo_valid & img_ro_valid & self_still;

  logic [CW-1:0] count_inc;
  assign count_inc = count + 1'b1;

  logic signed [W1-1:0] dst_s;
  logic                 avg_pos;
  assign dst_s   = $signed({1'b0, req_img_dst});
  assign avg_pos = ~avg[W1-1] & (avg != '0);

  logic [W1-1:0]       mag;
  logic                ok_c, ok_f;
  logic [C_LUT_AW-1:0] addr_c;
  assign mag  = err[W1-1] ? -err : err;
  assign ok_c = (mag < {1'b0, req_img_tol});
`ifdef AM_IMG_ADDR_CLAMP_EN
  logic over;
  assign over   = |mag[W1-1:C_LUT_AW];
  assign addr_c = over ? '1 : mag[C_LUT_AW-1:0];
  assign ok_f   = ok_c & ~over;
`else
  assign addr_c = mag[C_LUT_AW-1:0];
  assign ok_f   = ok_c;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC; self_mv <= 1'b0; dep_mv <= 1'b0;
      self_hist <= '0; dep_hist <= '0; acc <= '0; count <= '0;
      all_dep_still <= 1'b0; calc_step <= '0; wait_cnt <= '0;
      avg <= '0; err <= '0; needback <= 1'b0; ok <= 1'b0; lut_data <= '0;
      rd_addr <= '0; o_pulse <= 1'b0; o_step <= '0; o_ok <= 1'b0;
      o_should_start <= 1'b0; o_err <= '0;
    end else begin
      o_pulse <= 1'b0;
      o_step  <= '0;
      if (img_pulse) begin
        self_hist <= self_hist_new; dep_hist <= dep_hist_new;
        self_mv <= 1'b0; dep_mv <= 1'b0;
      end else begin
        self_mv <= self_now; dep_mv <= dep_now;
      end

      if (!enable) begin
        state <= ACC; count <= '0; acc <= '0;
      end else if (img_pulse && done_if_img_invalid) begin
        o_pulse <= 1'b1; o_ok <= 1'b1; o_should_start <= 1'b0;
        state <= ACC; count <= '0; acc <= '0;
      end else begin
        case (state)
          ACC: if (img_pulse) begin
            if (accept) begin
              acc           <= acc + pos_ext;
              count         <= count_inc;
              all_dep_still <= (all_dep_still | (count == '0)) & dep_still;
              if (count_inc == CW'(NF)) begin
                state <= CALC; calc_step <= '0;
              end
            end else begin
              count <= '0; acc <= '0; all_dep_still <= 1'b1;
            end
          end
          CALC: begin
            calc_step <= calc_step + 1'b1;
            if (calc_step == 2'd0) avg <= W1'(acc >>> C_AVG_LOG2);
            else if (calc_step == 2'd1) err <= avg_pos ? avg - dst_s : avg + dst_s;
            else begin
              needback <= err[W1-1] | (err == '0);
              ok       <= ok_f;
              rd_addr  <= addr_c;
              wait_cnt <= '0;
              state    <= LUT;
            end
          end
          // One extra cycle beyond the LUT latency so rd_data is captured stable.
          LUT: begin
            lut_data <= rd_data;
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == 3'(C_LUT_LATENCY)) state <= EMIT;
          end
          EMIT: begin
            o_pulse        <= 1'b1;
            o_step         <= needback ? -lut_data : lut_data;
            o_ok           <= all_dep_still & ok;
            o_should_start <= ~ok;
            o_err          <= err;
            state <= ACC; count <= '0; acc <= '0;
          end
          default: state <= ACC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_am_img_avg.sv
// Testbench for am_img_avg: vector table, hand-written corner sequences and randomized frames against a behavioural model.
module tb_am_img_avg;
  localparam int IMG_HW = 12, SW = 32, AVGL = 2, AW = 10, LAT = 2;
  localparam int NF = 1 << AVGL;

  logic clk = 1'b0;
  logic reset, enable, l2r, done_if_img_invalid, req_ecf, req_dep_img;
  logic [IMG_HW-1:0] req_img_dst, req_img_tol;
  logic img_pulse, img_l_valid, img_r_valid, img_lo_valid, img_ro_valid;
  logic [IMG_HW-1:0] img_lo_y, img_ro_y, img_li_y, img_ri_y;
  logic img_li_valid, img_ri_valid, m_state, m_dep_state;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic o_pulse, o_ok, o_should_start;
  logic [SW-1:0] o_step;
  logic [IMG_HW:0] o_err;

  am_img_avg #(.C_IMG_HW(IMG_HW), .C_STEP_NUMBER_WIDTH(SW), .C_AVG_LOG2(AVGL),
               .C_LUT_AW(AW), .C_LUT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .l2r(l2r),
    .done_if_img_invalid(done_if_img_invalid), .req_ecf(req_ecf), .req_dep_img(req_dep_img),
    .req_img_dst(req_img_dst), .req_img_tol(req_img_tol), .img_pulse(img_pulse),
    .img_l_valid(img_l_valid), .img_r_valid(img_r_valid),
    .img_lo_valid(img_lo_valid), .img_ro_valid(img_ro_valid),
    .img_lo_y(img_lo_y), .img_ro_y(img_ro_y),
    .img_li_valid(img_li_valid), .img_ri_valid(img_ri_valid),
    .img_li_y(img_li_y), .img_ri_y(img_ri_y),
    .m_state(m_state), .m_dep_state(m_dep_state),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .o_pulse(o_pulse), .o_step(o_step), .o_ok(o_ok),
    .o_should_start(o_should_start), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // External step LUT with LAT cycles of read latency.
  int unsigned lut_mem [1 << AW];
  logic [SW-1:0] lut_pipe [LAT];
  always @(posedge clk) begin
    lut_pipe[0] <= lut_mem[rd_addr];
    for (int i = 1; i < LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
  end
  assign rd_data = lut_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due; int step; bit ok; bit ss; bit chk_err; int err; bit chk_addr; int addr;
  } exp_t;
  exp_t exq[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;

  function automatic exp_t mkexp(int due, int step, bit ok, bit ss, bit ce, int err, bit ca, int addr);
    exp_t e;
    e.due = due; e.step = step; e.ok = ok; e.ss = ss;
    e.chk_err = ce; e.err = err; e.chk_addr = ca; e.addr = addr;
    return e;
  endfunction

  // Every result strobe is one transaction, matched against the expectation queue.
  exp_t me;
  always begin
    @(negedge clk); #1;
    if (mon_en) begin
      while (exq.size() > 0 && exq[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse due_cycle %0d now %0d", exq[0].due, cyc);
        void'(exq.pop_front());
      end
      checks++;
      if (o_pulse) begin
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cycle %0d step %0d err %0d", cyc, $signed(o_step), $signed(o_err));
        end else begin
          me = exq.pop_front();
          if (cyc != me.due || $signed(o_step) != me.step || o_ok != me.ok ||
              o_should_start != me.ss || (me.chk_err && $signed(o_err) != me.err) ||
              (me.chk_addr && int'(rd_addr) != me.addr)) begin
            errors++;
            $display("FAIL pulse got cyc %0d step %0d ok %0d start %0d err %0d addr %0d, want cyc %0d step %0d ok %0d start %0d err %0d addr %0d",
                     cyc, $signed(o_step), o_ok, o_should_start, $signed(o_err), rd_addr,
                     me.due, me.step, me.ok, me.ss, me.err, me.addr);
          end else
            $display("pulse cyc %0d step %0d ok %0d start %0d err %0d addr %0d",
                     cyc, $signed(o_step), o_ok, o_should_start, $signed(o_err), rd_addr);
        end
      end else if (o_step != '0) begin
        errors++;
        $display("FAIL step_idle cycle %0d got %0d want 0", cyc, $signed(o_step));
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int floor_div(int a, int d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  // Behavioural model state.
  int  win[$];
  bit  dep_all, prev_sm, prev_dm, use_model;
  int  busy_until = -1;

  // Drives one frame (optionally preceded by a motion blip); returns the cycle its strobe was sampled.
  task automatic frame(input int lo, ro, li, ri, input bit l2r_i, ecf_i, liv, riv, vld, sm, dm,
                       input int gap, output int n);
    int od, id, pos, sum, avg, err, mag, addr, step;
    bit s_still, d_still, okm;
    if (sm) m_state = 1'b1;
    if (dm) m_dep_state = 1'b1;
    @(negedge clk);
    m_state = 1'b0; m_dep_state = 1'b0;
    repeat (gap - 2) @(negedge clk);
    img_lo_y = IMG_HW'(lo); img_ro_y = IMG_HW'(ro); img_li_y = IMG_HW'(li); img_ri_y = IMG_HW'(ri);
    l2r = l2r_i; req_ecf = ecf_i; img_li_valid = liv; img_ri_valid = riv; img_lo_valid = vld;
    img_pulse = 1'b1;
    @(negedge clk);
    img_pulse = 1'b0;
    n = cyc;
    s_still = !(sm || prev_sm); d_still = !(dm || prev_dm);
    prev_sm = sm; prev_dm = dm;
    if (use_model && n > busy_until) begin
      if (vld && s_still) begin
        od  = l2r_i ? lo - ro : ro - lo;
        id  = l2r_i ? li - ri : ri - li;
        pos = (ecf_i && liv && riv) ? id - floor_div(od - id, 4) : od;
        if (win.size() == 0) dep_all = 1'b1;
        dep_all = dep_all & d_still;
        win.push_back(pos);
        if (win.size() == NF) begin
          sum = 0;
          foreach (win[k]) sum += win[k];
          avg = floor_div(sum, NF);
          err = (avg > 0) ? avg - int'(req_img_dst) : avg + int'(req_img_dst);
          mag = (err < 0) ? -err : err;
          okm = (mag < int'(req_img_tol));
`ifdef AM_IMG_ADDR_CLAMP_EN
          addr = (mag >= (1 << AW)) ? (1 << AW) - 1 : mag;
          if (mag >= (1 << AW)) okm = 1'b0;
`else
          addr = mag % (1 << AW);
`endif
          step = (err <= 0) ? -int'(lut_mem[addr]) : int'(lut_mem[addr]);
          exq.push_back(mkexp(n + 5 + LAT, step, dep_all & okm, !okm, 1'b1, err, 1'b1, addr));
          busy_until = n + 5 + LAT;
          win.delete();
        end
      end else
        win.delete();
    end
  endtask

  task automatic apply_od(input bit l2r_i, ecf_i, input int od, id, input bit sm, dm,
                          input int gap, output int n);
    if (l2r_i) frame(1000 + od, 1000, 1000 + id, 1000, 1'b1, ecf_i, 1'b1, 1'b1, 1'b1, sm, dm, gap, n);
    else       frame(1000, 1000 + od, 1000, 1000 + id, 1'b0, ecf_i, 1'b1, 1'b1, 1'b1, sm, dm, gap, n);
  endtask

  typedef struct {
    bit l2r; bit ecf; int o0, o1, o2, o3; int id; int dst; int tol;
    int err; int step; bit ok; bit ss; int addr;
  } vec_t;

  function automatic vec_t mk(bit l2r_i, ecf_i, int o0, o1, o2, o3, id_i, dst_i, tol_i,
                              int err_i, step_i, bit ok_i, ss_i, int addr_i);
    vec_t v;
    v.l2r = l2r_i; v.ecf = ecf_i; v.o0 = o0; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.id = id_i;
    v.dst = dst_i; v.tol = tol_i; v.err = err_i; v.step = step_i; v.ok = ok_i; v.ss = ss_i; v.addr = addr_i;
    return v;
  endfunction

  localparam int NV = 7;
  vec_t vt [NV];

  initial begin
    int n, n4, ods[4];
    for (int a = 0; a < (1 << AW); a++) lut_mem[a] = a * 7 + 3;
    lut_mem[0] = 7; lut_mem[10] = 55;
    for (int i = 0; i < LAT; i++) lut_pipe[i] = '0;

    // LUT: a*7+3 except [0]=7, [10]=55.
    vt[0] = mk(1, 0, 103, 102, 98, 102, 0, 100, 4,    1,   10, 1, 0,  1);
    vt[1] = mk(1, 0, 90, 90, 90, 90,     0, 100, 4,  -10,  -55, 0, 1, 10);
    vt[2] = mk(0, 1, 40, 40, 40, 40,    20,   0, 2,   15,  108, 0, 1, 15);
    vt[3] = mk(1, 0, -50, -51, -50, -50, 0, 100, 60,  49,  346, 1, 0, 49);
    vt[4] = mk(1, 1, 60, 60, 60, 60,   100, 100, 11,  10,   55, 1, 0, 10);
`ifdef AM_IMG_ADDR_CLAMP_EN
    vt[5] = mk(1, 0, 2100, 2100, 2100, 2100, 0, 100, 4, 2000, 7164, 0, 1, 1023);
`else
    vt[5] = mk(1, 0, 2100, 2100, 2100, 2100, 0, 100, 4, 2000, 6835, 0, 1, 976);
`endif
    vt[6] = mk(1, 0, -300, -300, -300, -300, 0, 100, 250, -200, -1403, 1, 0, 200);

    reset = 1'b1; enable = 1'b1; l2r = 1'b1; done_if_img_invalid = 1'b0; req_ecf = 1'b0;
    req_dep_img = 1'b1; req_img_dst = '0; req_img_tol = '0; img_pulse = 1'b0;
    img_l_valid = 1'b1; img_r_valid = 1'b1; img_lo_valid = 1'b1; img_ro_valid = 1'b1;
    img_li_valid = 1'b1; img_ri_valid = 1'b1;
    img_lo_y = '0; img_ro_y = '0; img_li_y = '0; img_ri_y = '0;
    m_state = 1'b0; m_dep_state = 1'b0;
    prev_sm = 1'b0; prev_dm = 1'b0; use_model = 1'b0; dep_all = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_o_pulse", int'(o_pulse), 0);
    chk("rst_o_step", int'(o_step), 0);
    chk("rst_o_ok", int'(o_ok), 0);
    chk("rst_o_should_start", int'(o_should_start), 0);
    chk("rst_o_err", int'(o_err), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    mon_en = 1'b1;

    for (int v = 0; v < NV; v++) begin
      req_img_dst = IMG_HW'(vt[v].dst); req_img_tol = IMG_HW'(vt[v].tol);
      ods[0] = vt[v].o0; ods[1] = vt[v].o1; ods[2] = vt[v].o2; ods[3] = vt[v].o3;
      for (int k = 0; k < NF; k++) apply_od(vt[v].l2r, vt[v].ecf, ods[k], vt[v].id, 1'b0, 1'b0, 3, n);
      exq.push_back(mkexp(n + 5 + LAT, vt[v].step, vt[v].ok, vt[v].ss, 1'b1, vt[v].err, 1'b1, vt[v].addr));
      repeat (12) @(negedge clk);
    end

    req_img_dst = 12'd100; req_img_tol = 12'd4;
    // Bypass on an invalid frame, then bypass aborting a calculation in flight.
    done_if_img_invalid = 1'b1;
    frame(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, n);
    exq.push_back(mkexp(n, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
    done_if_img_invalid = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < NF; k++) apply_od(1, 0, 90, 0, 1'b0, 1'b0, 3, n);
    done_if_img_invalid = 1'b1;
    frame(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, n);
    exq.push_back(mkexp(n, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
    done_if_img_invalid = 1'b0;
    repeat (12) @(negedge clk);

    // Self motion before frame 3: frames 3 and 4 fall in the motion history, 5..8 form the window.
    apply_od(1, 0, 300, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 300, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 300, 0, 1'b1, 1'b0, 3, n);
    apply_od(1, 0, 300, 0, 1'b0, 1'b0, 3, n);
    for (int k = 0; k < NF; k++) apply_od(1, 0, 90, 0, 1'b0, 1'b0, 3, n);
    exq.push_back(mkexp(n + 5 + LAT, -55, 1'b0, 1'b1, 1'b1, -10, 1'b1, 10));
    repeat (12) @(negedge clk);

    // Dependent motor moved inside the window: position ok but o_ok must drop.
    apply_od(1, 0, 101, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 101, 0, 1'b0, 1'b1, 3, n);
    apply_od(1, 0, 101, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 101, 0, 1'b0, 1'b0, 3, n);
    exq.push_back(mkexp(n + 5 + LAT, 10, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1));
    repeat (12) @(negedge clk);

    // A frame arriving while the result is being computed is not accumulated.
    for (int k = 0; k < NF; k++) apply_od(1, 0, 90, 0, 1'b0, 1'b0, 3, n);
    n4 = n;
    exq.push_back(mkexp(n4 + 5 + LAT, -55, 1'b0, 1'b1, 1'b1, -10, 1'b1, 10));
    apply_od(1, 0, 900, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 110, 0, 1'b0, 1'b0, 6, n);
    apply_od(1, 0, 110, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 110, 0, 1'b0, 1'b0, 3, n);
    repeat (12) @(negedge clk);
    apply_od(1, 0, 110, 0, 1'b0, 1'b0, 3, n);
    exq.push_back(mkexp(n + 5 + LAT, 55, 1'b0, 1'b1, 1'b1, 10, 1'b1, 10));
    repeat (12) @(negedge clk);

    // Dropping enable clears the partial count.
    apply_od(1, 0, 300, 0, 1'b0, 1'b0, 3, n);
    apply_od(1, 0, 300, 0, 1'b0, 1'b0, 3, n);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < NF; k++) apply_od(1, 0, 90, 0, 1'b0, 1'b0, 3, n);
    exq.push_back(mkexp(n + 5 + LAT, -55, 1'b0, 1'b1, 1'b1, -10, 1'b1, 10));
    repeat (12) @(negedge clk);

    // Reset during the calculation: no strobe, outputs back to zero.
    for (int k = 0; k < NF; k++) apply_od(1, 0, 90, 0, 1'b0, 1'b0, 3, n);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_sm = 1'b0; prev_dm = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_o_ok", int'(o_ok), 0);
    chk("midrst_o_err", int'(o_err), 0);
    chk("midrst_rd_addr", int'(rd_addr), 0);

    // Randomized frames checked against the behavioural model.
    use_model = 1'b1; win.delete(); busy_until = -1;
    req_img_dst = IMG_HW'($urandom_range(0, 600));
    req_img_tol = IMG_HW'($urandom_range(0, 400));
    for (int f = 0; f < 300; f++) begin
      frame($urandom_range(200, 1800), $urandom_range(200, 1800),
            $urandom_range(200, 1800), $urandom_range(200, 1800),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(2, 12), n);
    end
    repeat (20) @(negedge clk);
    chk("pending_expectations", exq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
